// File: rtl/except_pkg.sv
// Shared types and constants for the precise-exception controller.
// Holds ExcCode values, except-vector bit positions, FSM states and the lane snapshot record.
package except_pkg;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    localparam int EB_FETCH_ADEL = 7;
    localparam int EB_SYS        = 6;
    localparam int EB_BP         = 5;
    localparam int EB_ERET       = 4;
    localparam int EB_RI         = 3;
    localparam int EB_OV         = 2;
    localparam int EB_LOAD_ADEL  = 1;
    localparam int EB_ADES       = 0;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DRAIN  = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_DRAIN  = DRAIN,
        ST_COMMIT = COMMIT
    } state_t;

    // Lane index field is sized for up to 16 lanes; the top trims it to its own width.
    localparam int LANE_IDX_W = 4;

    typedef struct packed {
        logic [4:0]            code;
        logic                  is_eret;
        logic [31:0]           epc;
        logic [31:0]           bad_addr;
        logic                  bd;
        logic [31:0]           target;
        logic [LANE_IDX_W-1:0] lane;
    } lane_snap_t;

    function automatic logic irq_pending(input logic [31:0] status, input logic [31:0] cause);
        return ((cause[15:8] & status[15:8]) != 8'h00) && !status[1] && status[0];
    endfunction

endpackage

// File: rtl/except_ctrl_if.sv
// Lane, CP0 and commit signals between the pipeline (master) and except_ctrl (slave).
interface except_ctrl_if #(parameter int LANES = 2);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic                    stall;
    logic [LANES-1:0]        lane_valid;
    logic [LANES-1:0][7:0]   lane_except;
    logic [LANES-1:0][31:0]  lane_pc;
    logic [LANES-1:0][31:0]  lane_daddr;
    logic [LANES-1:0]        lane_bd;
    logic [31:0]             cp0_status;
    logic [31:0]             cp0_cause;
    logic [31:0]             cp0_epc;
    logic                    mem_busy;

    logic                    busy;
    logic                    flush;
    logic                    except_valid;
    logic [4:0]              except_code;
    logic                    except_is_eret;
    logic [31:0]             except_epc;
    logic [31:0]             except_bad_addr;
    logic                    except_bd;
    logic [31:0]             except_target;
    logic [LW-1:0]           except_lane;
    logic                    drain_timeout;

    modport master (
        output stall, lane_valid, lane_except, lane_pc, lane_daddr, lane_bd,
               cp0_status, cp0_cause, cp0_epc, mem_busy,
        input  busy, flush, except_valid, except_code, except_is_eret, except_epc,
               except_bad_addr, except_bd, except_target, except_lane, drain_timeout
    );

    modport slave (
        input  stall, lane_valid, lane_except, lane_pc, lane_daddr, lane_bd,
               cp0_status, cp0_cause, cp0_epc, mem_busy,
        output busy, flush, except_valid, except_code, except_is_eret, except_epc,
               except_bad_addr, except_bd, except_target, except_lane, drain_timeout
    );
endinterface

// File: rtl/except_lane_enc.sv
// Per-lane exception encoder: resolves one lane's except bits (or an attached
// interrupt) into a hit flag and the snapshot that would be committed for it.
module except_lane_enc
    import except_pkg::*;
#(
    parameter int          LANE_ID    = 0,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic        valid,
    input  logic [7:0]  except_bits,
    input  logic [31:0] pc,
    input  logic [31:0] daddr,
    input  logic        bd,
    input  logic        irq_attach,
    input  logic [31:0] cp0_epc,
    output logic        hit,
    output lane_snap_t  snap
);

    always_comb begin
        hit           = valid && ((except_bits != 8'h00) || irq_attach);
        snap          = '0;
        snap.lane     = LANE_IDX_W'(LANE_ID);
        snap.bd       = bd;
        snap.epc      = bd ? (pc - 32'd4) : pc;
        snap.target   = EXC_VECTOR;
        // Chain order is the architectural priority, not the bit order.
        if (irq_attach) begin
            snap.code = EXC_INT;
        end else if (except_bits[EB_FETCH_ADEL]) begin
            snap.code     = EXC_ADEL;
            snap.bad_addr = pc;
        end else if (except_bits[EB_RI]) begin
            snap.code = EXC_RI;
        end else if (except_bits[EB_OV]) begin
            snap.code = EXC_OV;
        end else if (except_bits[EB_SYS]) begin
            snap.code = EXC_SYS;
        end else if (except_bits[EB_BP]) begin
            snap.code = EXC_BP;
        end else if (except_bits[EB_ERET]) begin
            snap.is_eret = 1'b1;
            snap.code    = EXC_INT;
            snap.epc     = '0;
            snap.target  = cp0_epc;
        end else if (except_bits[EB_LOAD_ADEL]) begin
            snap.code     = EXC_ADEL;
            snap.bad_addr = daddr;
        end else if (except_bits[EB_ADES]) begin
            snap.code     = EXC_ADES;
            snap.bad_addr = daddr;
        end
    end

endmodule

// File: rtl/except_ctrl.sv
// N-lane precise-exception controller: capture oldest excepting lane, drain memory, pulse commit.
// Optional EXCEPT_PERF_CNT_EN adds saturating per-class commit counters.
module except_ctrl
    import except_pkg::*;
#(
    parameter int          LANES      = 2,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter int          DRAIN_MAX  = 15
) (
    input  logic          clk,
    input  logic          rst,
    except_ctrl_if.slave  bus
`ifdef EXCEPT_PERF_CNT_EN
    ,
    output logic [31:0]   perf_int_cnt,
    output logic [31:0]   perf_exc_cnt,
    output logic [31:0]   perf_eret_cnt
`endif
);

    localparam int CNT_W = $clog2(DRAIN_MAX + 1);
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    logic              irq;
    logic [LANES:0]    older_valid;
    logic [LANES-1:0]  irq_attach;
    logic [LANES-1:0]  lane_hit;
    lane_snap_t        lane_snap [LANES];
    lane_snap_t        win_snap;

    logic [1:0]        state_reg;
    lane_snap_t        snap_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              timeout_reg;
    logic              commit;

    assign irq            = irq_pending(bus.cp0_status, bus.cp0_cause) && (bus.lane_valid != '0);
    assign older_valid[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign older_valid[gi+1] = older_valid[gi] | bus.lane_valid[gi];
            // An interrupt rides on the oldest valid lane only.
            assign irq_attach[gi]    = irq && bus.lane_valid[gi] && !older_valid[gi];

            except_lane_enc #(
                .LANE_ID    (gi),
                .EXC_VECTOR (EXC_VECTOR)
            ) u_enc (
                .valid       (bus.lane_valid[gi]),
                .except_bits (bus.lane_except[gi]),
                .pc          (bus.lane_pc[gi]),
                .daddr       (bus.lane_daddr[gi]),
                .bd          (bus.lane_bd[gi]),
                .irq_attach  (irq_attach[gi]),
                .cp0_epc     (bus.cp0_epc),
                .hit         (lane_hit[gi]),
                .snap        (lane_snap[gi])
            );
        end
    endgenerate

    // Scanning youngest to oldest leaves the oldest hitting lane as winner.
    always_comb begin
        win_snap = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (lane_hit[i]) win_snap = lane_snap[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            snap_reg    <= '0;
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if ((lane_hit != '0) && !bus.stall) begin
                        snap_reg  <= win_snap;
                        cnt_reg   <= '0;
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!bus.mem_busy) begin
                        state_reg <= COMMIT;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == CNT_W'(DRAIN_MAX - 1)) begin
                            state_reg   <= COMMIT;
                            timeout_reg <= 1'b1;
                        end
                    end
                end
                COMMIT:  state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign commit              = (state_reg == COMMIT);
    assign bus.busy            = (state_reg != IDLE);
    assign bus.flush           = commit;
    assign bus.except_valid    = commit;
    assign bus.except_code     = commit ? snap_reg.code     : '0;
    assign bus.except_is_eret  = commit ? snap_reg.is_eret  : 1'b0;
    assign bus.except_epc      = commit ? snap_reg.epc      : '0;
    assign bus.except_bad_addr = commit ? snap_reg.bad_addr : '0;
    assign bus.except_bd       = commit ? snap_reg.bd       : 1'b0;
    assign bus.except_target   = commit ? snap_reg.target   : '0;
    assign bus.except_lane     = commit ? snap_reg.lane[LW-1:0] : '0;
    assign bus.drain_timeout   = timeout_reg;

`ifdef EXCEPT_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_int_cnt  <= '0;
            perf_exc_cnt  <= '0;
            perf_eret_cnt <= '0;
        end else if (commit) begin
            if (snap_reg.is_eret) begin
                if (perf_eret_cnt != '1) perf_eret_cnt <= perf_eret_cnt + 1'b1;
            end else if (snap_reg.code == EXC_INT) begin
                if (perf_int_cnt != '1) perf_int_cnt <= perf_int_cnt + 1'b1;
            end else begin
                if (perf_exc_cnt != '1) perf_exc_cnt <= perf_exc_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_except_ctrl.sv
// Directed bench for except_ctrl: behavioural model checked every cycle plus literal spot checks.
module tb_except_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    except_ctrl_if #(.LANES(2)) bus ();

    except_ctrl #(
        .LANES      (2),
        .EXC_VECTOR (32'hBFC00380),
        .DRAIN_MAX  (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model state: a pending capture, its drain age, and a commit cycle flag.
    bit          m_pend, m_commit, m_to;
    int          m_drain;
    logic [4:0]  m_code;
    bit          m_eret, m_bd;
    logic [31:0] m_epc, m_bad, m_tgt;
    int          m_lane;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Decide from the architectural rules which lane wins and what it reports.
    task automatic pick(output bit found, output logic [4:0] code, output bit eret,
                        output logic [31:0] epc, output logic [31:0] badv,
                        output logic [31:0] tgt, output bit bd, output int lane);
        int order [8] = '{7, 3, 2, 6, 5, 4, 1, 0};
        int codes [8] = '{4, 10, 12, 8, 9, 0, 4, 5};
        bit irq;
        int oldest;
        logic [7:0] ex;
        found = 0; code = 0; eret = 0; epc = 0; badv = 0; tgt = 0; bd = 0; lane = 0;
        irq = ((bus.cp0_cause[15:8] & bus.cp0_status[15:8]) != 0) && !bus.cp0_status[1]
              && bus.cp0_status[0] && (bus.lane_valid != 0);
        oldest = -1;
        for (int i = 0; i < 2; i++) if (bus.lane_valid[i] && oldest < 0) oldest = i;
        for (int i = 0; i < 2; i++) begin
            ex = bus.lane_except[i];
            if (!found && bus.lane_valid[i] && (ex != 0 || (irq && i == oldest))) begin
                found = 1;
                lane  = i;
                bd    = bus.lane_bd[i];
                tgt   = 32'hBFC00380;
                epc   = bus.lane_bd[i] ? bus.lane_pc[i] - 32'd4 : bus.lane_pc[i];
                if (irq && i == oldest) begin
                    code = 0;
                end else begin
                    for (int k = 0; k < 8; k++) begin
                        if (ex[order[k]]) begin
                            code = 5'(codes[k]);
                            if (order[k] == 4) begin
                                eret = 1; epc = 0; tgt = bus.cp0_epc;
                            end
                            if (order[k] == 7) badv = bus.lane_pc[i];
                            if (order[k] == 1 || order[k] == 0) badv = bus.lane_daddr[i];
                            break;
                        end
                    end
                end
            end
        end
    endtask

    always @(posedge clk) begin
        bit f;
        if (rst) begin
            m_pend = 0; m_commit = 0; m_to = 0; m_drain = 0;
        end else if (m_commit) begin
            m_commit = 0;
        end else if (m_pend) begin
            if (!bus.mem_busy) begin
                m_pend = 0; m_commit = 1;
            end else if (m_drain + 1 == 15) begin
                m_pend = 0; m_commit = 1; m_to = 1;
            end else begin
                m_drain++;
            end
        end else if (!bus.stall) begin
            pick(f, m_code, m_eret, m_epc, m_bad, m_tgt, m_bd, m_lane);
            if (f) begin
                m_pend = 1; m_drain = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [108:0] act, exp;
        if (chk_en) begin
            act = {bus.busy, bus.flush, bus.except_valid, bus.except_code, bus.except_is_eret,
                   bus.except_epc, bus.except_bad_addr, bus.except_bd, bus.except_target,
                   bus.except_lane, bus.drain_timeout};
            if (m_commit)
                exp = {1'b1, 1'b1, 1'b1, m_code, m_eret, m_epc, m_bad, m_bd, m_tgt,
                       1'(m_lane), m_to};
            else
                exp = {m_pend, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, m_to};
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL cycle_outputs @%0t: got %h want %h", $time, act, exp);
            end
        end
    end

    task automatic clear_lanes();
        bus.lane_valid  = '0;
        bus.lane_except = '0;
        bus.lane_pc     = '0;
        bus.lane_daddr  = '0;
        bus.lane_bd     = '0;
    endtask

    task automatic set_lane(input int i, input logic [7:0] e, input logic [31:0] pc,
                            input logic [31:0] da, input logic bd);
        bus.lane_valid[i]  = 1'b1;
        bus.lane_except[i] = e;
        bus.lane_pc[i]     = pc;
        bus.lane_daddr[i]  = da;
        bus.lane_bd[i]     = bd;
    endtask

    // Capture on the next edge, drop the lanes, then wait for the commit pulse.
    task automatic run(input string name, input int exp_lat);
        int n;
        bit seen;
        @(posedge clk);
        #2 clear_lanes();
        seen = 0;
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.except_valid) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL %s_no_pulse: got none want pulse within 40 cycles", name);
        end else begin
            chk({name, "_latency"}, 32'(n), 32'(exp_lat));
        end
        $display("txn %s: code=%0h lane=%0d epc=%0h bad=%0h tgt=%0h eret=%0d bd=%0d",
                 name, bus.except_code, bus.except_lane, bus.except_epc,
                 bus.except_bad_addr, bus.except_target, bus.except_is_eret, bus.except_bd);
    endtask

    task automatic realign();
        @(posedge clk);
        #2;
    endtask

    initial begin
        bit quiet;
        clear_lanes();
        bus.stall = 0; bus.mem_busy = 0;
        bus.cp0_status = 0; bus.cp0_cause = 0; bus.cp0_epc = 0;
        repeat (2) @(posedge clk);
        #2 chk_en = 1;
        @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_valid", 32'(bus.except_valid), 0);
        chk("reset_timeout", 32'(bus.drain_timeout), 0);
        realign();
        rst = 0;

        // Sys on lane 1, lane 0 clean
        set_lane(0, 8'h00, 32'hBFC000FC, 0, 0);
        set_lane(1, 8'h40, 32'hBFC00100, 0, 0);
        run("sys_lane1", 2);
        chk("sys_code", 32'(bus.except_code), 32'h08);
        chk("sys_lane", 32'(bus.except_lane), 1);
        chk("sys_epc", bus.except_epc, 32'hBFC00100);
        chk("sys_target", bus.except_target, 32'hBFC00380);
        realign();

        // Load AdEL on lane 0 beats Sys on lane 1
        set_lane(0, 8'h02, 32'hBFC00200, 32'h80000003, 0);
        set_lane(1, 8'h40, 32'hBFC00204, 0, 0);
        run("adel_lane0", 2);
        chk("adel_code", 32'(bus.except_code), 32'h04);
        chk("adel_bad", bus.except_bad_addr, 32'h80000003);
        chk("adel_lane", 32'(bus.except_lane), 0);
        realign();

        // Interrupt attached to lane 0 in a delay slot
        bus.cp0_cause = 32'h0400; bus.cp0_status = 32'h0401;
        set_lane(0, 8'h00, 32'hBFC00208, 0, 1);
        run("irq_bd", 2);
        chk("irq_code", 32'(bus.except_code), 32'h00);
        chk("irq_epc", bus.except_epc, 32'hBFC00204);
        chk("irq_bd", 32'(bus.except_bd), 1);
        realign();

        // Interrupt attaches to lane 1 when lane 0 is empty
        set_lane(1, 8'h00, 32'h80001000, 0, 0);
        run("irq_lane1", 2);
        chk("irq1_lane", 32'(bus.except_lane), 1);
        chk("irq1_epc", bus.except_epc, 32'h80001000);
        realign();

        // EXL set masks the interrupt: nothing captured
        bus.cp0_status = 32'h0403;
        set_lane(0, 8'h00, 32'hBFC00300, 0, 0);
        repeat (3) @(negedge clk);
        chk("irq_masked_busy", 32'(bus.busy), 0);
        realign();
        clear_lanes();
        bus.cp0_cause = 0; bus.cp0_status = 0;

        // ERET
        bus.cp0_epc = 32'hBFC00500;
        set_lane(0, 8'h10, 32'hBFC00400, 0, 0);
        run("eret", 2);
        chk("eret_flag", 32'(bus.except_is_eret), 1);
        chk("eret_target", bus.except_target, 32'hBFC00500);
        chk("eret_code", 32'(bus.except_code), 0);
        realign();

        // Stall blocks capture; Bp captured once stall drops
        bus.stall = 1;
        set_lane(0, 8'h20, 32'h80002000, 0, 0);
        repeat (3) @(negedge clk);
        chk("stall_busy", 32'(bus.busy), 0);
        realign();
        bus.stall = 0;
        run("bp_after_stall", 2);
        chk("bp_code", 32'(bus.except_code), 32'h09);
        realign();

        // Intra-lane priority cases
        set_lane(0, 8'h88, 32'h00000102, 32'h1234, 0);
        run("fetch_over_ri", 2);
        chk("fetch_code", 32'(bus.except_code), 32'h04);
        chk("fetch_bad", bus.except_bad_addr, 32'h00000102);
        realign();
        set_lane(0, 8'h00, 32'h80003000, 0, 0);
        set_lane(1, 8'h44, 32'h80003004, 0, 0);
        run("ov_over_sys", 2);
        chk("ov_code", 32'(bus.except_code), 32'h0C);
        realign();
        set_lane(0, 8'h01, 32'h80004000, 32'h80000006, 0);
        run("ades", 2);
        chk("ades_code", 32'(bus.except_code), 32'h05);
        chk("ades_bad", bus.except_bad_addr, 32'h80000006);
        realign();

        // A few cycles of mem_busy delay the commit
        bus.mem_busy = 1;
        set_lane(0, 8'h40, 32'h80005000, 0, 0);
        @(posedge clk);
        #2 clear_lanes();
        repeat (3) @(posedge clk);
        #2 bus.mem_busy = 0;
        repeat (3) @(negedge clk);
        realign();

        // mem_busy stuck: forced commit after 15 drain cycles
        bus.mem_busy = 1;
        set_lane(0, 8'h40, 32'h80006000, 0, 0);
        run("timeout", 16);
        chk("timeout_flag", 32'(bus.drain_timeout), 1);
        repeat (4) @(posedge clk);
        #2 bus.mem_busy = 0;
        realign();
        chk("timeout_sticky", 32'(bus.drain_timeout), 1);

        // Reset during DRAIN aborts without a pulse
        bus.mem_busy = 1;
        set_lane(0, 8'h40, 32'h80007000, 0, 0);
        @(posedge clk);
        #2 clear_lanes();
        repeat (2) @(posedge clk);
        #2 rst = 1;
        @(posedge clk);
        #2 rst = 0;
        bus.mem_busy = 0;
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_timeout", 32'(bus.drain_timeout), 0);
        quiet = 1;
        repeat (20) begin
            @(negedge clk);
            if (bus.except_valid) quiet = 0;
        end
        chk("rst_no_pulse", 32'(quiet), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/except_ctrl.md
Name: except_ctrl

Overview:
- N-lane precise-exception controller for the multi-issue MIPS pipeline, placed at the memory/commit boundary.
- Each cycle it selects the oldest excepting lane, or attaches a pending interrupt to the oldest valid lane, and snapshots that lane's state.
- It then holds the pipeline until outstanding memory traffic drains, and issues a one-cycle commit pulse carrying cause, EPC, BadVAddr, branch-delay flag and redirect target to CP0 and fetch.

Parameters:
- LANES, 2, issue lanes; lane 0 is oldest.
- EXC_VECTOR, 32'hBFC00380, general exception redirect target.
- DRAIN_MAX, 15, DRAIN cycles tolerated before forced commit; counter width is $clog2(DRAIN_MAX+1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  1  pipeline stall; no capture while high
- lane_valid  in  LANES  lane holds a real instruction
- lane_except  in  LANES×8  per-lane exception vector: bit7 fetch AdEL, 6 Sys, 5 Bp, 4 ERET, 3 RI, 2 Ov, 1 load AdEL, 0 AdES
- lane_pc  in  LANES×32  lane PC
- lane_daddr  in  LANES×32  lane data address
- lane_bd  in  LANES  lane is in a branch delay slot
- cp0_status  in  32  Status
- cp0_cause  in  32  Cause
- cp0_epc  in  32  EPC
- mem_busy  in  1  older memory access outstanding
- busy  out  1  controller holding the pipeline
- flush  out  1  flush all stages (one cycle)
- except_valid  out  1  commit pulse (one cycle)
- except_code  out  5  ExcCode
- except_is_eret  out  1  commit is an ERET
- except_epc  out  32  EPC to write
- except_bad_addr  out  32  BadVAddr
- except_bd  out  1  Cause.BD
- except_target  out  32  redirect PC
- except_lane  out  $clog2(LANES)  winning lane
- drain_timeout  out  1  sticky: a forced commit occurred

Behaviour:
- Reset: all outputs 0; state IDLE; snapshot and counter cleared. Reset taken mid-DRAIN/COMMIT aborts with no pulse.
- Interrupt pending: (cause[15:8]&status[15:8])!=0, status[1]=0, status[0]=1, and at least one lane_valid.
- Lane selection:
  - A lane qualifies if it is valid and (its except!=0 or it is the oldest valid lane with an interrupt pending).
  - The lowest-index qualifying lane wins; younger lanes are discarded.
- Per-lane priority: Int(0x00) > fetch AdEL(0x04) > RI(0x0A) > Ov(0x0C) > Sys(0x08) > Bp(0x09) > ERET > load AdEL(0x04) > AdES(0x05).
- BadVAddr: lane_pc for fetch AdEL, lane_daddr for data AdEL/AdES, else 0.
- EPC: lane_pc-4 if lane_bd, else lane_pc.
- Target: cp0_epc for ERET, else EXC_VECTOR. ERET sets except_is_eret=1, except_code=0, and does not write EPC.
- FSM IDLE:
  - If a lane qualifies and !stall: register the snapshot, go to DRAIN, busy=1 from the next cycle.
  - If stall is high: no capture.
- FSM DRAIN:
  - mem_busy=0 → COMMIT.
  - Otherwise increment the counter. On reaching DRAIN_MAX → COMMIT and set drain_timeout (sticky until rst).
  - Lane inputs are ignored in this state.
- FSM COMMIT: except_valid=1 and flush=1 for exactly one cycle, busy=1; then IDLE. Snapshot outputs stay valid only in this cycle; they are 0 otherwise.
- Latency: capture at edge T; earliest pulse in cycle T+2 (DRAIN lasts one cycle when mem_busy=0).
- A new capture is possible in the cycle after COMMIT. Flushed lanes must present lane_valid=0 by then.

Optional Feature:
- Macro EXCEPT_PERF_CNT_EN.
- Defined: adds outputs perf_int_cnt, perf_exc_cnt, perf_eret_cnt (32-bit each). Each increments on the commit pulse of its class, saturates at 2^32-1, and clears on rst.
- Undefined: the ports and counters are absent; all other behaviour is unchanged.

Decomposition:
- except_pkg:
  - ExcCode localparams: INT, ADEL, ADES, SYS, BP, RI, OV.
  - Except-bit index localparams.
  - state_t enum: IDLE, DRAIN, COMMIT.
  - lane_snap_t struct: code, is_eret, epc, bad_addr, bd, target, lane.
- Sub-module: except_lane_enc, combinational, one instance per lane. It maps except, pc, daddr, bd and irq_attach to a hit flag plus lane_snap_t.

Test Plan:
- Lane1 except=8'h40 (Sys), lane0 clean, pc1=0xBFC00100, mem_busy=0 → pulse at T+2: code=0x08, lane=1, epc=0xBFC00100, target=0xBFC00380.
- Lane0 except=8'h02, daddr0=0x80000003; lane1 except=8'h40 → lane 0 wins: code=0x04, bad_addr=0x80000003; lane1 ignored.
- IRQ pending (cause=0x0400, status=0x0401), lane0 bd=1, pc0=0xBFC00208 → code=0x00, epc=0xBFC00204, bd=1.
- Lane0 except=8'h10, cp0_epc=0xBFC00500 → is_eret=1, target=0xBFC00500, code=0.
- mem_busy held high for 20 cycles → commit after 15 DRAIN cycles, drain_timeout=1 until rst.
- rst asserted in DRAIN → next cycle IDLE with all outputs 0 and no except_valid pulse.
